// File: rtl/tcp_rx_reader.sv
// tcp_rx_reader: receive engine for the TCP offload user port.
// Takes session notifications, issues chunked read requests of at most
// MAX_RD_LEN bytes, checks each returned meta, emits a per-chunk descriptor
// and then streams that chunk's payload straight through to the user.
module tcp_rx_reader #(
    parameter int MAX_RD_LEN = 4096,
    parameter int CNT_BITS   = 32
) (
    input  logic                aclk,
    input  logic                areset,

    // notification from the stack
    input  logic                s_notify_valid,
    output logic                s_notify_ready,
    input  logic [15:0]         s_notify_sid,
    input  logic [15:0]         s_notify_len,
    input  logic [31:0]         s_notify_ip,
    input  logic [15:0]         s_notify_dst_port,
    input  logic                s_notify_closed,

    // read request to the stack
    output logic                m_rd_pkg_valid,
    input  logic                m_rd_pkg_ready,
    output logic [15:0]         m_rd_pkg_sid,
    output logic [15:0]         m_rd_pkg_len,

    // per-read meta returned by the stack
    input  logic                s_rx_meta_valid,
    output logic                s_rx_meta_ready,
    input  logic [15:0]         s_rx_meta_sid,
    input  logic [15:0]         s_rx_meta_len,

    // payload from the stack
    input  logic                s_axis_rx_tvalid,
    output logic                s_axis_rx_tready,
    input  logic [511:0]        s_axis_rx_tdata,
    input  logic [63:0]         s_axis_rx_tkeep,
    input  logic                s_axis_rx_tlast,

    // per-chunk descriptor: {sid, len, rsvd, last, err}
    output logic                m_desc_valid,
    input  logic                m_desc_ready,
    output logic [47:0]         m_desc_data,

    // closed-session notice
    output logic                m_close_valid,
    input  logic                m_close_ready,
    output logic [15:0]         m_close_data,

    // payload to the user
    output logic                m_axis_rx_tvalid,
    input  logic                m_axis_rx_tready,
    output logic [511:0]        m_axis_rx_tdata,
    output logic [63:0]         m_axis_rx_tkeep,
    output logic                m_axis_rx_tlast,

    output logic [CNT_BITS-1:0] stat_bytes,
    output logic [CNT_BITS-1:0] stat_err
);

    localparam logic [16:0] MAX_LEN17 = 17'(MAX_RD_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_META,
        ST_DESC,
        ST_DATA,
        ST_CLOSE
    } state_t;

    state_t              state_reg, state_next;
    logic [15:0]         sid_reg, sid_next;
    logic [15:0]         rem_reg, rem_next;
    logic [15:0]         chunk_reg, chunk_next;
    logic [16:0]         bcnt_reg, bcnt_next;
    logic                err_reg, err_next;
    logic [CNT_BITS-1:0] stat_bytes_reg, stat_bytes_next;
    logic [CNT_BITS-1:0] stat_err_reg, stat_err_next;

    logic [15:0]         req_chunk;
    logic [6:0]          keep_cnt;
    logic [16:0]         bcnt_sum;
    logic                beat_fire;

    // address and port of the session are not needed by this engine
    logic unused_notify_fields;
    assign unused_notify_fields = ^{s_notify_ip, s_notify_dst_port};

    // next request size: the remainder, capped at the per-read maximum
    assign req_chunk = ({1'b0, rem_reg} > MAX_LEN17) ? MAX_LEN17[15:0] : rem_reg;

    // number of valid bytes in the current payload beat
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < 64; i++) begin
            keep_cnt = keep_cnt + {6'd0, s_axis_rx_tkeep[i]};
        end
    end

    assign bcnt_sum  = bcnt_reg + {10'd0, keep_cnt};
    assign beat_fire = (state_reg == ST_DATA) && s_axis_rx_tvalid && m_axis_rx_tready;

    // payload fields pass straight through; only the handshake is gated by state
    assign m_axis_rx_tdata = s_axis_rx_tdata;
    assign m_axis_rx_tkeep = s_axis_rx_tkeep;
    assign m_axis_rx_tlast = s_axis_rx_tlast;

    assign m_rd_pkg_sid = sid_reg;
    assign m_rd_pkg_len = req_chunk;
    assign m_desc_data  = {sid_reg, chunk_reg, 14'd0, (rem_reg == 16'd0), err_reg};
    assign m_close_data = sid_reg;
    assign stat_bytes   = stat_bytes_reg;
    assign stat_err     = stat_err_reg;

    // next-state, datapath updates and handshake outputs
    always_comb begin
        state_next       = state_reg;
        sid_next         = sid_reg;
        rem_next         = rem_reg;
        chunk_next       = chunk_reg;
        bcnt_next        = bcnt_reg;
        err_next         = err_reg;
        stat_bytes_next  = stat_bytes_reg;
        stat_err_next    = stat_err_reg;
        s_notify_ready   = 1'b0;
        m_rd_pkg_valid   = 1'b0;
        s_rx_meta_ready  = 1'b0;
        m_desc_valid     = 1'b0;
        m_close_valid    = 1'b0;
        s_axis_rx_tready = 1'b0;
        m_axis_rx_tvalid = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // held low while reset is asserted so ready rises only once it clears
                s_notify_ready = !areset;
                if (s_notify_valid) begin
                    sid_next = s_notify_sid;
                    rem_next = s_notify_len;
                    if (s_notify_closed) begin
                        state_next = ST_CLOSE;
                    end else if (s_notify_len != 16'd0) begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                m_rd_pkg_valid = 1'b1;
                if (m_rd_pkg_ready) begin
                    chunk_next = req_chunk;
                    rem_next   = rem_reg - req_chunk;
                    state_next = ST_META;
                end
            end
            ST_META: begin
                s_rx_meta_ready = 1'b1;
                if (s_rx_meta_valid) begin
                    err_next   = (s_rx_meta_sid != sid_reg) || (s_rx_meta_len != chunk_reg);
                    state_next = ST_DESC;
                end
            end
            ST_DESC: begin
                m_desc_valid = 1'b1;
                if (m_desc_ready) begin
                    bcnt_next  = '0;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                s_axis_rx_tready = m_axis_rx_tready;
                m_axis_rx_tvalid = s_axis_rx_tvalid;
                if (beat_fire) begin
                    stat_bytes_next = stat_bytes_reg + CNT_BITS'(keep_cnt);
                    bcnt_next       = bcnt_sum;
                    if (s_axis_rx_tlast) begin
                        bcnt_next = '0;
                        if (bcnt_sum != {1'b0, chunk_reg}) begin
                            err_next = 1'b1;
                        end
                        // one count per bad chunk, whichever check caught it
                        if (err_reg || (bcnt_sum != {1'b0, chunk_reg})) begin
                            stat_err_next = stat_err_reg + CNT_BITS'(1);
                        end
                        state_next = (rem_reg != 16'd0) ? ST_REQ : ST_IDLE;
                    end
                end
            end
            ST_CLOSE: begin
                m_close_valid = 1'b1;
                if (m_close_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // state and datapath registers; reset abandons any chunk in flight
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= ST_IDLE;
            sid_reg        <= '0;
            rem_reg        <= '0;
            chunk_reg      <= '0;
            bcnt_reg       <= '0;
            err_reg        <= 1'b0;
            stat_bytes_reg <= '0;
            stat_err_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            sid_reg        <= sid_next;
            rem_reg        <= rem_next;
            chunk_reg      <= chunk_next;
            bcnt_reg       <= bcnt_next;
            err_reg        <= err_next;
            stat_bytes_reg <= stat_bytes_next;
            stat_err_reg   <= stat_err_next;
        end
    end

endmodule

// File: tb/tb_tcp_rx_reader.sv
// Testbench for tcp_rx_reader: emulates the stack and the user side,
// compares requests, descriptors, payload bytes and counters against a
// chunking model computed directly from notification lengths.
module tb_tcp_rx_reader;

    localparam int MAXL = 4096;
    localparam int CB   = 32;

    logic         aclk = 1'b0;
    logic         areset;
    logic         s_notify_valid, s_notify_ready;
    logic [15:0]  s_notify_sid, s_notify_len, s_notify_dst_port;
    logic [31:0]  s_notify_ip;
    logic         s_notify_closed;
    logic         m_rd_pkg_valid, m_rd_pkg_ready;
    logic [15:0]  m_rd_pkg_sid, m_rd_pkg_len;
    logic         s_rx_meta_valid, s_rx_meta_ready;
    logic [15:0]  s_rx_meta_sid, s_rx_meta_len;
    logic         s_axis_rx_tvalid, s_axis_rx_tready;
    logic [511:0] s_axis_rx_tdata;
    logic [63:0]  s_axis_rx_tkeep;
    logic         s_axis_rx_tlast;
    logic         m_desc_valid, m_desc_ready;
    logic [47:0]  m_desc_data;
    logic         m_close_valid, m_close_ready;
    logic [15:0]  m_close_data;
    logic         m_axis_rx_tvalid, m_axis_rx_tready;
    logic [511:0] m_axis_rx_tdata;
    logic [63:0]  m_axis_rx_tkeep;
    logic         m_axis_rx_tlast;
    logic [CB-1:0] stat_bytes, stat_err;

    always #5 aclk = ~aclk;

    tcp_rx_reader #(.MAX_RD_LEN(MAXL), .CNT_BITS(CB)) dut (
        .aclk(aclk), .areset(areset),
        .s_notify_valid(s_notify_valid), .s_notify_ready(s_notify_ready),
        .s_notify_sid(s_notify_sid), .s_notify_len(s_notify_len),
        .s_notify_ip(s_notify_ip), .s_notify_dst_port(s_notify_dst_port),
        .s_notify_closed(s_notify_closed),
        .m_rd_pkg_valid(m_rd_pkg_valid), .m_rd_pkg_ready(m_rd_pkg_ready),
        .m_rd_pkg_sid(m_rd_pkg_sid), .m_rd_pkg_len(m_rd_pkg_len),
        .s_rx_meta_valid(s_rx_meta_valid), .s_rx_meta_ready(s_rx_meta_ready),
        .s_rx_meta_sid(s_rx_meta_sid), .s_rx_meta_len(s_rx_meta_len),
        .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tready(s_axis_rx_tready),
        .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tkeep(s_axis_rx_tkeep),
        .s_axis_rx_tlast(s_axis_rx_tlast),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready), .m_desc_data(m_desc_data),
        .m_close_valid(m_close_valid), .m_close_ready(m_close_ready), .m_close_data(m_close_data),
        .m_axis_rx_tvalid(m_axis_rx_tvalid), .m_axis_rx_tready(m_axis_rx_tready),
        .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
        .m_axis_rx_tlast(m_axis_rx_tlast),
        .stat_bytes(stat_bytes), .stat_err(stat_err)
    );

    int errors = 0;
    int checks = 0;
    bit bp = 1'b0;
    int timeouts = 0;
    int stab_viol = 0;
    int tlast_cnt = 0;
    byte unsigned exp_bytes[$];
    byte unsigned got_bytes[$];
    logic [31:0]  rd_q[$];
    logic [47:0]  desc_q[$];
    int           rd_wait_q[$];
    int           desc_wait_q[$];
    logic [31:0]  exp_stat_bytes = '0;
    logic [31:0]  exp_stat_err = '0;

    // ---------------- reference model ----------------
    function automatic int model_nchunks(input int len);
        return (len + MAXL - 1) / MAXL;
    endfunction

    function automatic int model_chunk(input int len, input int k);
        int r;
        r = len - k * MAXL;
        return (r > MAXL) ? MAXL : r;
    endfunction

    // expected counter movement for one notification
    function automatic void model_xfer(input int len, input bit meta_bad, input int short_b);
        exp_stat_bytes = exp_stat_bytes + 32'(len - short_b);
        if (meta_bad) exp_stat_err = exp_stat_err + 32'(model_nchunks(len));
        else if (short_b > 0) exp_stat_err = exp_stat_err + 32'd1;
    endfunction

    function automatic logic [47:0] model_desc(input logic [15:0] sid, input int len,
                                               input int k, input bit err);
        return {sid, 16'(model_chunk(len, k)), 14'd0, 1'(k == model_nchunks(len) - 1), err};
    endfunction

    function automatic int byte_mismatches();
        int m;
        m = 0;
        if (got_bytes.size() != exp_bytes.size()) m++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) m++;
        return m;
    endfunction

    function automatic bit rnd_ready();
        return bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // ---------------- stack / user emulation ----------------
    task automatic drive_notify(input logic [15:0] sid, input logic [15:0] len, input logic closed);
        bit done;
        done = 1'b0;
        s_notify_ip       = $urandom;
        s_notify_dst_port = 16'($urandom);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge aclk);
            s_notify_valid  = 1'b1;
            s_notify_sid    = sid;
            s_notify_len    = len;
            s_notify_closed = closed;
            #1;
            if (s_notify_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end else begin
            timeouts++;
        end
        s_notify_valid = 1'b0;
    endtask

    task automatic serve_rd(output logic [15:0] sid, output logic [15:0] len,
                            output int wait_cyc, output bit ok);
        bit pend;
        logic [31:0] prev;
        pend = 1'b0; prev = '0; ok = 1'b0; sid = '0; len = '0; wait_cyc = -1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge aclk);
            m_rd_pkg_ready = rnd_ready();
            #1;
            if (pend && (!m_rd_pkg_valid || {m_rd_pkg_sid, m_rd_pkg_len} !== prev)) stab_viol++;
            if (m_rd_pkg_valid && wait_cyc < 0) wait_cyc = n;
            if (m_rd_pkg_valid && m_rd_pkg_ready) begin
                ok = 1'b1; sid = m_rd_pkg_sid; len = m_rd_pkg_len;
            end
            pend = m_rd_pkg_valid && !m_rd_pkg_ready;
            prev = {m_rd_pkg_sid, m_rd_pkg_len};
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end else begin
            timeouts++;
        end
        m_rd_pkg_ready = 1'b0;
    endtask

    task automatic serve_meta(input logic [15:0] sid, input logic [15:0] len);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge aclk);
            s_rx_meta_valid = 1'b1;
            s_rx_meta_sid   = sid;
            s_rx_meta_len   = len;
            #1;
            if (s_rx_meta_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end else begin
            timeouts++;
        end
        s_rx_meta_valid = 1'b0;
    endtask

    task automatic serve_desc(output logic [47:0] d, output int wait_cyc, output bit ok);
        bit pend;
        logic [47:0] prev;
        pend = 1'b0; prev = '0; ok = 1'b0; d = '0; wait_cyc = -1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge aclk);
            m_desc_ready = rnd_ready();
            #1;
            if (pend && (!m_desc_valid || m_desc_data !== prev)) stab_viol++;
            if (m_desc_valid && wait_cyc < 0) wait_cyc = n;
            if (m_desc_valid && m_desc_ready) begin
                ok = 1'b1; d = m_desc_data;
            end
            pend = m_desc_valid && !m_desc_ready;
            prev = m_desc_data;
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end else begin
            timeouts++;
        end
        m_desc_ready = 1'b0;
    endtask

    // sends nbytes as full 64 B beats plus a partial tail; optional empty tlast beat
    task automatic serve_payload(input int nbytes, input bit zero_tail);
        int nbeats, total, b, cnt;
        bit have;
        logic [511:0] d;
        logic [63:0]  k;
        byte unsigned v;
        nbeats = (nbytes + 63) / 64;
        if (nbeats == 0) nbeats = 1;
        total = nbeats + (zero_tail ? 1 : 0);
        b = 0; have = 1'b0;
        for (int n = 0; n < 8000 && b < total; n++) begin
            @(negedge aclk);
            if (!have) begin
                cnt = (b < nbeats) ? nbytes - b * 64 : 0;
                if (cnt > 64) cnt = 64;
                if (cnt < 0) cnt = 0;
                for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
                k = '0;
                for (int l = 0; l < cnt; l++) begin
                    v = 8'($urandom);
                    d[l*8 +: 8] = v;
                    k[l] = 1'b1;
                    exp_bytes.push_back(v);
                end
                s_axis_rx_tdata = d;
                s_axis_rx_tkeep = k;
                s_axis_rx_tlast = (b == total - 1);
                have = 1'b1;
            end
            s_axis_rx_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_rx_tready = rnd_ready();
            #1;
            if (m_axis_rx_tvalid && m_axis_rx_tready) begin
                for (int l = 0; l < 64; l++)
                    if (m_axis_rx_tkeep[l]) got_bytes.push_back(m_axis_rx_tdata[l*8 +: 8]);
                if (m_axis_rx_tlast) tlast_cnt++;
            end
            if (s_axis_rx_tvalid && s_axis_rx_tready) begin
                b++;
                have = 1'b0;
            end
        end
        if (b >= total) begin
            @(posedge aclk);
            #1;
        end else begin
            timeouts++;
        end
        s_axis_rx_tvalid = 1'b0;
        m_axis_rx_tready = 1'b0;
    endtask

    // one full notification: requests, metas, descriptors and payload
    task automatic do_xfer(input logic [15:0] sid, input int len, input bit meta_bad,
                           input int short_b, input bit zero_tail);
        logic [15:0] rs, rl;
        logic [47:0] d;
        int w, req, k, nb;
        bit ok;
        rd_q.delete(); desc_q.delete(); rd_wait_q.delete(); desc_wait_q.delete();
        exp_bytes.delete(); got_bytes.delete(); tlast_cnt = 0;
        drive_notify(sid, 16'(len), 1'b0);
        req = 0; k = 0; ok = 1'b1;
        while (ok && req < len && k < 40) begin
            serve_rd(rs, rl, w, ok);
            if (!ok) break;
            rd_q.push_back({rs, rl});
            rd_wait_q.push_back(w);
            req += int'(rl);
            serve_meta(meta_bad ? rs + 16'd1 : rs, rl);
            serve_desc(d, w, ok);
            if (!ok) break;
            desc_q.push_back(d);
            desc_wait_q.push_back(w);
            nb = int'(rl) - ((k == 0) ? short_b : 0);
            if (nb < 0) nb = 0;
            serve_payload(nb, zero_tail);
            k++;
        end
        $display("xfer sid=%0d len=%0d meta_bad=%0d short=%0d chunks=%0d bytes_out=%0d",
                 sid, len, meta_bad, short_b, rd_q.size(), got_bytes.size());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        checks++;
        if ({s_notify_ready, m_rd_pkg_valid, s_rx_meta_ready, m_desc_valid, m_close_valid,
             s_axis_rx_tready, m_axis_rx_tvalid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshakes got=%b exp=0000000",
                     {s_notify_ready, m_rd_pkg_valid, s_rx_meta_ready, m_desc_valid,
                      m_close_valid, s_axis_rx_tready, m_axis_rx_tvalid});
        end
        checks++;
        if (stat_bytes !== 32'd0 || stat_err !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stat_bytes, stat_err);
        end
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if (s_notify_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", s_notify_ready);
        end
        exp_stat_bytes = '0;
        exp_stat_err   = '0;
    endtask

    task automatic test_single;
        bp = 1'b0;
        do_xfer(16'd5, 100, 1'b0, 0, 1'b0);
        model_xfer(100, 1'b0, 0);
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== {16'd5, 16'd100}) begin
            errors++;
            $display("FAIL single_rd got_n=%0d first=%h exp=00050064", rd_q.size(),
                     (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
        checks++;
        if (desc_q.size() != 1 || desc_q[0] !== model_desc(16'd5, 100, 0, 1'b0)) begin
            errors++;
            $display("FAIL single_desc got=%h exp=%h", (desc_q.size() > 0) ? desc_q[0] : 48'h0,
                     model_desc(16'd5, 100, 0, 1'b0));
        end
        checks++;
        if (rd_wait_q.size() < 1 || rd_wait_q[0] != 0 || desc_wait_q.size() < 1 || desc_wait_q[0] != 0) begin
            errors++;
            $display("FAIL single_latency got_rd=%0d got_desc=%0d exp=0/0",
                     (rd_wait_q.size() > 0) ? rd_wait_q[0] : -1,
                     (desc_wait_q.size() > 0) ? desc_wait_q[0] : -1);
        end
        checks++;
        if (byte_mismatches() != 0 || tlast_cnt != 1) begin
            errors++;
            $display("FAIL single_payload mism=%0d tlast=%0d exp=0/1", byte_mismatches(), tlast_cnt);
        end
        checks++;
        if (stat_bytes !== exp_stat_bytes || stat_err !== exp_stat_err) begin
            errors++;
            $display("FAIL single_stats got=%0d/%0d exp=%0d/%0d", stat_bytes, stat_err,
                     exp_stat_bytes, exp_stat_err);
        end
    endtask

    task automatic test_split;
        int n, bad;
        bp = 1'b0;
        do_xfer(16'd11, 9000, 1'b0, 0, 1'b0);
        model_xfer(9000, 1'b0, 0);
        n = model_nchunks(9000);
        bad = 0;
        if (rd_q.size() != n || desc_q.size() != n) bad++;
        else for (int k = 0; k < n; k++) begin
            if (rd_q[k] !== {16'd11, 16'(model_chunk(9000, k))}) bad++;
            if (desc_q[k] !== model_desc(16'd11, 9000, k, 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL split_chunks got_n=%0d bad=%0d exp_n=%0d bad=0", rd_q.size(), bad, n);
        end
        checks++;
        if (byte_mismatches() != 0 || tlast_cnt != n) begin
            errors++;
            $display("FAIL split_payload mism=%0d tlast=%0d exp=0/%0d", byte_mismatches(), tlast_cnt, n);
        end
        checks++;
        if (stat_bytes !== exp_stat_bytes) begin
            errors++;
            $display("FAIL split_stat_bytes got=%0d exp=%0d", stat_bytes, exp_stat_bytes);
        end
    endtask

    task automatic test_close_zero;
        bit done, pend;
        int rd_seen, busy;
        logic [15:0] got;
        done = 1'b0; pend = 1'b0; rd_seen = 0; got = '0; busy = 0;
        drive_notify(16'd7, 16'd0, 1'b1);
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge aclk);
            m_close_ready = (n >= 2);
            #1;
            if (m_rd_pkg_valid) rd_seen++;
            if (pend && (!m_close_valid || m_close_data !== 16'd7)) stab_viol++;
            if (m_close_valid && m_close_ready) begin
                done = 1'b1; got = m_close_data;
            end
            pend = m_close_valid && !m_close_ready;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end
        m_close_ready = 1'b0;
        $display("xfer close sid=7 got=%0d", got);
        checks++;
        if (!done || got !== 16'd7 || rd_seen != 0) begin
            errors++;
            $display("FAIL close_sid done=%0d got=%0d rd=%0d exp=1/7/0", done, got, rd_seen);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (s_notify_ready !== 1'b1) begin
            errors++;
            $display("FAIL close_ready_after got=%b exp=1", s_notify_ready);
        end
        drive_notify(16'd9, 16'd0, 1'b0);
        $display("xfer zero_len sid=9");
        @(negedge aclk);
        #1;
        checks++;
        if (s_notify_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_ready got=%b exp=1", s_notify_ready);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge aclk);
            #1;
            if (m_rd_pkg_valid || m_desc_valid || m_close_valid) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL zero_len_quiet got=%0d exp=0", busy);
        end
    endtask

    task automatic test_mismatch;
        bp = 1'b0;
        do_xfer(16'd5, 100, 1'b1, 0, 1'b0);
        model_xfer(100, 1'b1, 0);
        checks++;
        if (desc_q.size() != 1 || desc_q[0] !== model_desc(16'd5, 100, 0, 1'b1)) begin
            errors++;
            $display("FAIL meta_sid_desc got=%h exp=%h", (desc_q.size() > 0) ? desc_q[0] : 48'h0,
                     model_desc(16'd5, 100, 0, 1'b1));
        end
        checks++;
        if (stat_err !== exp_stat_err) begin
            errors++;
            $display("FAIL meta_sid_stat_err got=%0d exp=%0d", stat_err, exp_stat_err);
        end
        do_xfer(16'd5, 100, 1'b0, 10, 1'b0);
        model_xfer(100, 1'b0, 10);
        checks++;
        if (desc_q.size() != 1 || desc_q[0] !== model_desc(16'd5, 100, 0, 1'b0)) begin
            errors++;
            $display("FAIL short_desc got=%h exp=%h", (desc_q.size() > 0) ? desc_q[0] : 48'h0,
                     model_desc(16'd5, 100, 0, 1'b0));
        end
        checks++;
        if (stat_err !== exp_stat_err || stat_bytes !== exp_stat_bytes || byte_mismatches() != 0) begin
            errors++;
            $display("FAIL short_stats got=%0d/%0d mism=%0d exp=%0d/%0d/0", stat_err, stat_bytes,
                     byte_mismatches(), exp_stat_err, exp_stat_bytes);
        end
        do_xfer(16'd6, 100, 1'b1, 10, 1'b0);
        model_xfer(100, 1'b1, 10);
        checks++;
        if (stat_err !== exp_stat_err) begin
            errors++;
            $display("FAIL both_err_once got=%0d exp=%0d", stat_err, exp_stat_err);
        end
    endtask

    task automatic test_boundary;
        int bad;
        bp = 1'b0;
        do_xfer(16'd20, MAXL, 1'b0, 0, 1'b0);
        model_xfer(MAXL, 1'b0, 0);
        checks++;
        if (rd_q.size() != 1 || desc_q.size() != 1 || desc_q[0] !== model_desc(16'd20, MAXL, 0, 1'b0)) begin
            errors++;
            $display("FAIL max_len_one_chunk got_n=%0d desc=%h exp_n=1 desc=%h", rd_q.size(),
                     (desc_q.size() > 0) ? desc_q[0] : 48'h0, model_desc(16'd20, MAXL, 0, 1'b0));
        end
        do_xfer(16'd21, MAXL + 1, 1'b0, 0, 1'b0);
        model_xfer(MAXL + 1, 1'b0, 0);
        bad = 0;
        if (rd_q.size() != 2 || desc_q.size() != 2) bad++;
        else for (int k = 0; k < 2; k++) begin
            if (rd_q[k] !== {16'd21, 16'(model_chunk(MAXL + 1, k))}) bad++;
            if (desc_q[k] !== model_desc(16'd21, MAXL + 1, k, 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_plus_one got_n=%0d bad=%0d exp_n=2 bad=0", rd_q.size(), bad);
        end
        do_xfer(16'd22, 64, 1'b0, 0, 1'b1);
        model_xfer(64, 1'b0, 0);
        checks++;
        if (stat_err !== exp_stat_err || stat_bytes !== exp_stat_bytes || tlast_cnt != 1) begin
            errors++;
            $display("FAIL empty_tlast got=%0d/%0d tlast=%0d exp=%0d/%0d/1", stat_err, stat_bytes,
                     tlast_cnt, exp_stat_err, exp_stat_bytes);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] sid;
        int len, n, bad;
        bp = 1'b1;
        for (int t = 0; t < 6; t++) begin
            sid = 16'($urandom);
            len = $urandom_range(1, 12000);
            do_xfer(sid, len, 1'b0, 0, 1'b0);
            model_xfer(len, 1'b0, 0);
            n = model_nchunks(len);
            bad = 0;
            if (rd_q.size() != n || desc_q.size() != n) bad++;
            else for (int k = 0; k < n; k++) begin
                if (rd_q[k] !== {sid, 16'(model_chunk(len, k))}) bad++;
                if (desc_q[k] !== model_desc(sid, len, k, 1'b0)) bad++;
            end
            checks++;
            if (bad != 0 || byte_mismatches() != 0) begin
                errors++;
                $display("FAIL bp_xfer%0d got_n=%0d bad=%0d mism=%0d exp_n=%0d bad=0 mism=0",
                         t, rd_q.size(), bad, byte_mismatches(), n);
            end
        end
        bp = 1'b0;
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL bp_valid_stable got=%0d exp=0", stab_viol);
        end
        checks++;
        if (stat_bytes !== exp_stat_bytes || stat_err !== exp_stat_err) begin
            errors++;
            $display("FAIL bp_stats got=%0d/%0d exp=%0d/%0d", stat_bytes, stat_err,
                     exp_stat_bytes, exp_stat_err);
        end
    endtask

    task automatic test_reset_in_data;
        logic [15:0] rs, rl;
        logic [47:0] d;
        int w, in_data;
        bit ok;
        bp = 1'b0;
        in_data = 0;
        drive_notify(16'd3, 16'd300, 1'b0);
        serve_rd(rs, rl, w, ok);
        serve_meta(rs, rl);
        serve_desc(d, w, ok);
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            for (int j = 0; j < 16; j++) s_axis_rx_tdata[j*32 +: 32] = $urandom;
            s_axis_rx_tkeep  = '1;
            s_axis_rx_tlast  = 1'b0;
            s_axis_rx_tvalid = 1'b1;
            m_axis_rx_tready = 1'b1;
            #1;
            if (s_axis_rx_tready && m_axis_rx_tvalid) in_data++;
        end
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        $display("xfer reset_mid_payload sid=3 beats_before=%0d", in_data);
        checks++;
        if (in_data != 2) begin
            errors++;
            $display("FAIL rst_data_reached got=%0d exp=2", in_data);
        end
        checks++;
        if ({s_notify_ready, m_rd_pkg_valid, s_rx_meta_ready, m_desc_valid, m_close_valid,
             s_axis_rx_tready, m_axis_rx_tvalid} !== 7'b0 || stat_bytes !== 32'd0 || stat_err !== 32'd0) begin
            errors++;
            $display("FAIL rst_data_outputs got=%b/%0d/%0d exp=0000000/0/0",
                     {s_notify_ready, m_rd_pkg_valid, s_rx_meta_ready, m_desc_valid,
                      m_close_valid, s_axis_rx_tready, m_axis_rx_tvalid}, stat_bytes, stat_err);
        end
        @(negedge aclk);
        areset = 1'b0;
        s_axis_rx_tvalid = 1'b0;
        m_axis_rx_tready = 1'b0;
        #1;
        checks++;
        if (s_notify_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_data_ready got=%b exp=1", s_notify_ready);
        end
        exp_stat_bytes = '0;
        exp_stat_err   = '0;
        do_xfer(16'd4, 200, 1'b0, 0, 1'b0);
        model_xfer(200, 1'b0, 0);
        checks++;
        if (rd_q.size() != 1 || desc_q.size() != 1 || desc_q[0] !== model_desc(16'd4, 200, 0, 1'b0)
            || byte_mismatches() != 0 || stat_bytes !== exp_stat_bytes) begin
            errors++;
            $display("FAIL rst_data_fresh got_n=%0d mism=%0d bytes=%0d exp_n=1 mism=0 bytes=%0d",
                     rd_q.size(), byte_mismatches(), stat_bytes, exp_stat_bytes);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_notify_valid = 1'b0; s_notify_sid = '0; s_notify_len = '0;
        s_notify_ip = '0; s_notify_dst_port = '0; s_notify_closed = 1'b0;
        m_rd_pkg_ready = 1'b0;
        s_rx_meta_valid = 1'b0; s_rx_meta_sid = '0; s_rx_meta_len = '0;
        s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0; s_axis_rx_tlast = 1'b0;
        m_desc_ready = 1'b0; m_close_ready = 1'b0; m_axis_rx_tready = 1'b0;

        test_reset();
        test_single();
        test_split();
        test_close_zero();
        test_mismatch();
        test_boundary();
        test_backpressure();
        test_reset_in_data();

        checks++;
        if (timeouts != 0) begin
            errors++;
            $display("FAIL handshake_timeouts got=%0d exp=0", timeouts);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tcp_rx_reader.md
# tcp_rx_reader

User-side receive engine for the TCP offload interface. It consumes notifications from `m_tcp_notify_u` and issues read requests on `s_tcp_rd_pkg_u`, splitting large notifications into chunks of at most `MAX_RD_LEN` bytes. For each chunk it accepts the returned `m_tcp_rx_meta_u` and forwards payload from `m_axis_tcp_rx_u` to the user kernel, with a per-chunk descriptor. It sits between the TCP slice array user ports and application logic.

## Interface
- `MAX_RD_LEN`, default 4096: maximum bytes per read request. Power of two, at least 64.
- `CNT_BITS`, default 32: width of the statistics counters.
- `aclk`, in, 1: clock.
- `areset`, in, 1: synchronous, active-high reset.
- `s_notify`, metaIntf.s, tcp_notify_t: `{sid[15:0], len[15:0], ip[31:0], dst_port[15:0], closed}` from the stack.
- `m_rd_pkg`, metaIntf.m, tcp_rd_pkg_t: `{sid, len}` read request to the stack.
- `s_rx_meta`, metaIntf.s, tcp_rx_meta_t: `{sid, len}` returned per read.
- `s_axis_rx`, AXI4S.s, 512-bit: payload from the stack (tdata, tkeep, tlast).
- `m_desc`, metaIntf.m, 48 bits: `{err[0], last[1], rsvd[15:2], len[31:16], sid[47:32]}`, one per chunk, sent before its payload.
- `m_close`, metaIntf.m, 16 bits: sid of a closed session.
- `m_axis_rx`, AXI4S.m, 512-bit: user payload. tlast marks the end of each chunk.
- `stat_bytes`, out, CNT_BITS: total payload bytes forwarded.
- `stat_err`, out, CNT_BITS: number of chunks with the error flag set.

## Operation
- **State machine:** IDLE, REQ, META, DESC, DATA, CLOSE.
- **IDLE**
  - `s_notify.ready`=1; all other handshake outputs are 0.
  - On accept, latch `sid` and `rem=len`.
  - If `closed`=1, go to CLOSE.
  - Else if `len`==0, drop the notification and stay in IDLE.
  - Else go to REQ.
- **REQ**
  - Drive `m_rd_pkg.valid`=1 with `{sid, chunk}`, where `chunk = min(rem, MAX_RD_LEN)`. Hold until ready.
  - On handshake: `rem -= chunk`, then go to META.
- **META**
  - `s_rx_meta.ready`=1.
  - On accept, set `err`=1 if `meta.sid`≠sid or `meta.len`≠chunk; otherwise err=0.
  - Go to DESC.
- **DESC**
  - Drive `m_desc.valid` with `{sid, chunk, last=(rem==0), err}`. Hold until ready, then go to DATA.
- **DATA**
  - Pass through: `m_axis_rx.tvalid = s_axis_rx.tvalid` and `s_axis_rx.tready = m_axis_rx.tready` (combinational).
  - Accumulate `bcnt += popcount(tkeep)` per beat.
  - On the tlast beat:
    - If the chunk byte count (including this beat) ≠ chunk, set err and increment `stat_err`. That chunk's descriptor has already gone out with its META-time err, so `stat_err` is the sole record of a byte mismatch.
    - If META had already set err, `stat_err` still increments only once for the chunk.
    - Next state is REQ if `rem`>0, else IDLE.
- **CLOSE**
  - Drive `m_close.valid` with sid. Hold until ready, then go to IDLE.
- **Counters**
  - `stat_bytes` adds `popcount(tkeep)` on every forwarded beat.
  - Both counters wrap modulo 2^CNT_BITS.
- **Widths**
  - `rem` and `chunk` are 16 bits.
  - `bcnt` is 17 bits, so it cannot overflow for `MAX_RD_LEN` ≤ 32768.
- **Ordering:** payload beats arriving outside DATA are not accepted (tready=0), so no data is lost.

## Timing
- **Reset:** state=IDLE; rem, bcnt, err and both counters = 0; every valid and ready output = 0. `s_notify.ready` goes to 1 in the first cycle after reset deasserts.
- **Reset mid-operation:** the state machine returns to IDLE at once, and any partial chunk is abandoned.
- **Latency:**
  - `m_rd_pkg.valid` asserts in the cycle after the notify handshake.
  - `m_desc.valid` asserts in the cycle after the rx_meta handshake.
  - The payload path adds 0 cycles.
- **Handshakes:** valid is held with stable data until ready; valid never depends on ready.
- **Notify throughput:** at most one notify is accepted per completed transaction. A new notify can be accepted in the cycle after the final tlast or the close handshake.
- **Boundaries:**
  - `len` == `MAX_RD_LEN` produces exactly one chunk with last=1.
  - `len` = k·`MAX_RD_LEN`+1 produces k+1 chunks, the final one of 1 byte.
  - A tlast beat with tkeep=0 contributes 0 bytes.

## Test plan
- **Single chunk:** notify {sid=5, len=100}; rx_meta {5, 100}; 2 beats (64 B, then 36 B with tlast).
  - rd_pkg {5, 100}.
  - desc {5, 100, last=1, err=0}.
  - stat_bytes=100, stat_err=0.
- **Split:** MAX_RD_LEN=4096, notify len=9000.
  - rd_pkg lengths 4096, 4096, 808 in order.
  - Three descriptors; only the third has last=1.
  - stat_bytes=9000.
- **Close and zero length:** notify {sid=7, closed=1} → m_close=7 and no rd_pkg. Notify len=0 → no outputs; notify.ready returns to 1 the next cycle.
- **Mismatch:**
  - rx_meta.sid=6 for a request on sid=5 → desc err=1, stat_err=1.
  - Payload of 90 B against chunk=100 → stat_err increments.
- **Backpressure:** randomise `m_axis_rx.tready`, `m_desc.ready` and `m_rd_pkg.ready` at 50%. Payload must stay byte-exact and in order; valids must be held stable.
- **Reset in DATA:** assert areset mid-payload.
  - All outputs return to reset values the next cycle.
  - A following fresh notify completes normally.
